bin_to_bcd_seq: RTL and testbench
=================================

# bin_to_bcd_seq

Sequential binary-to-BCD converter controller. Sequences a bank of `add3` correction cells through the shift-and-add-3 (double-dabble) algorithm, one bit per clock. Accepts a binary word over a valid/ready handshake and returns packed BCD digits over a second valid/ready handshake. Sits between counters or measurement logic and the seven-segment/display drivers.

## Interface
- `WIDTH`, default 16: binary input width, at least 1.
- `DIGITS`, default 5: BCD output digits.
  - Must satisfy 10^DIGITS > 2^WIDTH − 1.
  - Elaboration fails otherwise.
- `clk` input, 1: system clock, all state on rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `in_valid` input, 1: `bin_in` is valid.
- `in_ready` output, 1: block can accept a word.
- `bin_in` input, WIDTH: unsigned binary value.
- `out_valid` output, 1: `bcd_out` holds a finished result.
- `out_ready` input, 1: consumer accepts the result.
- `bcd_out` output, 4*DIGITS: packed BCD, digit 0 (units) in bits [3:0].
- `busy` output, 1: conversion in progress (SHIFT state).

## Operation
- States: IDLE, SHIFT, DONE.
- Working register `sr` is 4*DIGITS+WIDTH bits: BCD field on top, binary field below.
- Iteration counter `cnt` is $clog2(WIDTH+1) bits.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: load `sr` = {zeros, `bin_in`}, set `cnt`=WIDTH, go to SHIFT.
- **SHIFT**
  - Each cycle, every BCD digit of `sr` passes through `add3`: a digit of 5..9 gains 3, a digit of 0..4 passes unchanged.
  - The corrected register is then shifted left by 1, with 0 entering at the LSB.
  - `cnt` decrements each cycle.
  - When `cnt`=1, the shift completes, the top 4*DIGITS bits load into `bcd_out`, and the state goes to DONE.
- **DONE**
  - `out_valid`=1; `bcd_out` is stable.
  - On `out_ready`: go to IDLE, drop `out_valid`. `bcd_out` keeps its last value.
- `in_ready` is 1 only in IDLE. `in_valid` in SHIFT or DONE is ignored and the word is not latched.
- Digit values from `add3` never exceed 12 before the shift. After the shift every digit is 0..9. Digit inputs 10..15 are unreachable by construction.
- Value 0 still takes the full WIDTH cycles. There is no early exit.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `bcd_out`=0, `sr`=0, `cnt`=0.
- Input transfer occurs on the rising edge where `in_valid` && `in_ready`.
- `busy`=1 for exactly WIDTH cycles after acceptance.
- `out_valid` rises on the WIDTH-th edge after the acceptance edge. Latency is WIDTH cycles, so 16 for the defaults.
- Output transfer occurs on the edge where `out_valid` && `out_ready`.
  - `in_ready` rises on that same edge.
  - The next word can be accepted one cycle later.
  - Minimum throughput is one conversion per WIDTH+2 cycles.
- `out_ready` may be held high permanently. DONE then lasts exactly one cycle.
- `out_ready` low stalls indefinitely in DONE, and `bcd_out` stays constant.
- Asserting `rst_n` low in any state immediately (asynchronously) forces the reset values and discards any in-flight conversion. Reset release is synchronised externally.

## Structure
- Package `bcd_pkg` holds:
  - the state enum (IDLE, SHIFT, DONE);
  - a constant function `bcd_digits_for(width)` that returns the minimum DIGITS, used for the elaboration check.
- The sub-module is the existing `add3` correction cell, instantiated DIGITS times via generate, one per nibble of the BCD field.
- The FSM, counter and shift register are in this module.

## Test plan
- `bin_in`=0: accept, then after 16 cycles `bcd_out`=0x00000 and `out_valid`=1.
- `bin_in`=65535: `bcd_out`=0x65535 at exactly 16 cycles after acceptance. `busy` is high for 16 cycles.
- Back-to-back values 9, 10, 12345, 40960 with `out_ready` held high:
  - results are 0x00009, 0x00010, 0x12345, 0x40960;
  - spacing between acceptances is 18 cycles.
- Back-pressure: `bin_in`=999 with `out_ready` low for 10 cycles after `out_valid` rises.
  - `bcd_out`=0x00999 stays stable and `in_ready`=0 throughout.
  - An `in_valid` pulse carrying 1234 during that window is not converted.
- Reset mid-conversion: assert `rst_n` low 7 cycles into converting 54321.
  - All outputs return to reset values asynchronously.
  - After release, converting 100 yields 0x00100.
- Randomised cross-check over 1000 random 16-bit values against a reference model, with random `out_ready` stalls.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   state_t         : controller states (IDLE, SHIFT, DONE)
//   bcd_digits_for  : minimum BCD digit count that can hold 2**width - 1
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // The number of decimal digits of 2**w - 1 equals that of 2**w, because a
  // power of two is never a power of ten for w >= 1. That count is
  // floor(w * log10(2)) + 1. log10(2) is held in fixed point (1e-9 units),
  // which is exact enough for any practical width.
  function automatic int bcd_digits_for(input int width);
    longint prod;
    prod = longint'(width) * 64'sd301029995;
    return int'(prod / 64'sd1000000000) + 1;
  endfunction

endpackage

// File: rtl/add3.sv
// Double-dabble correction cell for one BCD digit.
//   d : digit before the shift
//   q : d + 3 when d is 5..9, otherwise d unchanged
// Inputs 10..15 cannot occur in a correctly sequenced converter.
module add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);

  always_comb begin
    q = d;
    if (d >= 4'd5) q = d + 4'd3;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one binary bit per clock.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : input handshake, bin_in carries the binary word
//   out_valid/out_ready : output handshake, bcd_out carries packed BCD
//                         (digit 0, the units, in bits [3:0])
//   busy                : high while the shift sequence is running
//
// Handshake semantics (both ports): a transfer happens on the rising edge
// where valid && ready are both high. in_ready is high only in IDLE, so a
// word offered while busy or while a result is pending is simply not taken.
// out_valid stays high and bcd_out stays constant until out_ready is seen.
// bcd_out keeps its last value after the output transfer.
//
// Latency is WIDTH cycles from acceptance to out_valid, independent of the
// value converted.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  busy
);

  localparam int BW  = 4 * DIGITS;
  localparam int SRW = BW + WIDTH;
  localparam int CW  = $clog2(WIDTH + 1);

  generate
    if (WIDTH < 1 || DIGITS < bcd_digits_for(WIDTH)) begin : g_bad_params
      $error("bin_to_bcd_seq: DIGITS too small for WIDTH (or WIDTH < 1)");
    end
  endgenerate

  state_t          state;
  state_t          state_n;
  logic [SRW-1:0]  sr;
  logic [CW-1:0]   cnt;
  logic [BW-1:0]   bcd_corr;
  logic [SRW-1:0]  sr_shift;
  logic            last;

  // One correction cell per nibble of the BCD field of the working register.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_add3
      add3 u_add3 (
        .d (sr[WIDTH + 4*gi +: 4]),
        .q (bcd_corr[4*gi +: 4])
      );
    end
  endgenerate

  // Correct every digit, then shift the whole register left with a 0 in.
  // The bit leaving the top is always 0 for in-range parameters.
  assign sr_shift = {bcd_corr, sr[WIDTH-1:0]} << 1;
  assign last     = (cnt == CW'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next state
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid)  state_n = SHIFT;
      SHIFT:   if (last)      state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default:                state_n = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == SHIFT);

  // Datapath: working register, iteration counter, result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr      <= '0;
      cnt     <= '0;
      bcd_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sr  <= {{BW{1'b0}}, bin_in};
            cnt <= CW'(WIDTH);
          end
        end
        SHIFT: begin
          sr  <= sr_shift;
          cnt <= cnt - CW'(1);
          if (last) bcd_out <= sr_shift[SRW-1 -: BW];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;

  localparam int WIDTH  = 16;
  localparam int DIGITS = 5;
  localparam int BW     = 4 * DIGITS;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  bin_in;
  logic              out_valid;
  logic              out_ready;
  logic [BW-1:0]     bcd_out;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [BW-1:0] exp_q[$];

  bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin_in    (bin_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd_out   (bcd_out),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [BW-1:0] ref_bcd(input int unsigned v);
    logic [BW-1:0] r;
    int unsigned   x;
    r = '0;
    x = v;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the acceptance edge.
  task automatic send(input logic [WIDTH-1:0] v, output time acc_t);
    int t;
    t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    in_valid = 1'b1;
    bin_in   = v;
    @(posedge clk);
    acc_t = $time;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called at the negedge after acceptance; counts cycles until out_valid.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    while (!out_valid && lat < 100) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: out_valid=%0b required 1", out_valid);
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    bin_in    = '0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_checks++; if (bcd_out !== 20'h00000) begin n_fail++; $display("FAIL reset_bcd_out: got %05h want 00000", bcd_out); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero();
    time t0;
    int  lat, bc;
    send(16'd0, t0);
    wait_done(lat, bc);
    n_checks++; if (lat != 16) begin n_fail++; $display("FAIL zero_latency: got %0d want 16", lat); end
    n_checks++; if (bcd_out !== 20'h00000) begin n_fail++; $display("FAIL zero_bcd: got %05h want 00000", bcd_out); end
    release_out();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL zero_out_valid_drop: got %0b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL zero_in_ready_back: got %0b want 1", in_ready); end
  endtask

  task automatic test_max();
    time t0;
    int  lat, bc;
    send(16'd65535, t0);
    wait_done(lat, bc);
    n_checks++; if (lat != 16) begin n_fail++; $display("FAIL max_latency: got %0d want 16", lat); end
    n_checks++; if (bc != 16) begin n_fail++; $display("FAIL max_busy_cycles: got %0d want 16", bc); end
    n_checks++; if (bcd_out !== 20'h65535) begin n_fail++; $display("FAIL max_bcd: got %05h want 65535", bcd_out); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL max_busy_in_done: got %0b want 0", busy); end
    release_out();
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] vals[4];
    logic [BW-1:0]    exps[4];
    time              t_acc, t_prev;
    int               lat, bc;
    vals[0] = 16'd9;     exps[0] = 20'h00009;
    vals[1] = 16'd10;    exps[1] = 20'h00010;
    vals[2] = 16'd12345; exps[2] = 20'h12345;
    vals[3] = 16'd40960; exps[3] = 20'h40960;
    out_ready = 1'b1;
    t_prev    = 0;
    for (int i = 0; i < 4; i++) begin
      send(vals[i], t_acc);
      if (i > 0) begin
        n_checks++;
        if ((t_acc - t_prev) != 180) begin
          n_fail++;
          $display("FAIL b2b_spacing[%0d]: got %0t want 180 (18 cycles)", i, t_acc - t_prev);
        end
      end
      t_prev = t_acc;
      wait_done(lat, bc);
      n_checks++;
      if (bcd_out !== exps[i]) begin
        n_fail++;
        $display("FAIL b2b_bcd[%0d]: got %05h want %05h", i, bcd_out, exps[i]);
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_done_one_cycle: got %0b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    time t0;
    int  lat, bc;
    int  bad;
    out_ready = 1'b0;
    send(16'd999, t0);
    wait_done(lat, bc);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        in_valid = 1'b1;
        bin_in   = 16'd1234;
      end else begin
        in_valid = 1'b0;
      end
      n_checks++;
      if (bcd_out !== 20'h00999 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall[%0d]: bcd=%05h in_ready=%0b out_valid=%0b want 00999/0/1",
                 i, bcd_out, in_ready, out_valid);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    release_out();
    n_checks++; if (bcd_out !== 20'h00999) begin n_fail++; $display("FAIL stall_bcd_hold: got %05h want 00999", bcd_out); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_word_ignored: busy=%0b in_ready=%0b want 0/1", busy, in_ready); end
  endtask

  task automatic test_reset_mid();
    time t0;
    int  lat, bc;
    send(16'd54321, t0);
    repeat (6) @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before_reset: got %0b want 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || bcd_out !== 20'h00000) begin
      n_fail++;
      $display("FAIL async_reset: in_ready=%0b out_valid=%0b busy=%0b bcd=%05h want 1/0/0/00000",
               in_ready, out_valid, busy, bcd_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(16'd100, t0);
    wait_done(lat, bc);
    n_checks++; if (lat != 16) begin n_fail++; $display("FAIL post_reset_latency: got %0d want 16", lat); end
    n_checks++; if (bcd_out !== 20'h00100) begin n_fail++; $display("FAIL post_reset_bcd: got %05h want 00100", bcd_out); end
    release_out();
  endtask

  task automatic test_random();
    time              t0;
    int               lat, bc;
    logic [WIDTH-1:0] v;
    logic [BW-1:0]    e;
    int               stall;
    for (int i = 0; i < 1000; i++) begin
      v = WIDTH'($urandom_range(0, 65535));
      exp_q.push_back(ref_bcd(int'(v)));
      send(v, t0);
      wait_done(lat, bc);
      stall = $urandom_range(0, 3);
      repeat (stall) @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (bcd_out !== e) begin
        n_fail++;
        $display("FAIL random[%0d]: in=%0d got %05h want %05h", i, v, bcd_out, e);
      end
      release_out();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_zero();
    test_max();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
